spi_host: RTL and testbench
===========================

# spi_host

SPI mode-0 command transmitter, the initiator for the FPGA-side SPI command receiver. It accepts a command word through a valid/ready handshake and serialises it MSB-first on `spi_clk`/`mosi` under an active-low chip select. It is used on the host board or in loopback benches to drive waveform-selector commands into the client.

## Interface
- `CMD_WIDTH`, default 4: command word width in bits. Matches the client's selector command width.
- `CLK_DIV`, default 8: `spi_clk` half-period in `clk` cycles. Must be ≥1; ≥4 when driving the synchronising client.
- `clk` in, 1: system clock. The block uses this single clock domain only.
- `rst` in, 1: synchronous, active-low reset.
- `cmd_data` in, `CMD_WIDTH`: command to send. Sampled only on accept.
- `cmd_valid` in, 1: command present.
- `cmd_ready` out, 1: block can accept. Accept happens when `cmd_valid && cmd_ready` at a rising `clk` edge.
- `busy` out, 1: frame in progress.
- `done` out, 1: one-cycle pulse at end of frame.
- `spi_clk` out, 1: serial clock, idle low.
- `mosi` out, 1: serial data.
- `cs` out, 1: chip select, active low.

## Operation
- All outputs are registered.
- **Reset values (while `rst`=0):** `cs`=1, `spi_clk`=0, `mosi`=0, `cmd_ready`=0, `busy`=0, `done`=0.
- **States:**
  - IDLE: `cmd_ready`=1, `cs`=1.
  - LOW: `cs`=0, `spi_clk`=0, `mosi` = current bit.
  - HIGH: `spi_clk`=1.
  - HOLD: `cs`=0, `spi_clk`=0, `mosi` holds the last bit.
  - GAP: `cs`=1, `spi_clk`=0.
- **Transitions:**
  - IDLE→LOW on accept. The shift register loads `cmd_data`, the bit counter loads `CMD_WIDTH-1`, and `cmd_ready` drops.
  - LOW→HIGH after `CLK_DIV` cycles.
  - HIGH→LOW after `CLK_DIV` cycles if bits remain. The shift register advances and `mosi` changes with the falling `spi_clk` edge.
  - HIGH→HOLD after the last bit's high phase.
  - HOLD→GAP after `CLK_DIV` cycles.
  - GAP→IDLE after `CLK_DIV` cycles. `done`=1 in the last GAP cycle.
- Data changes only on falling edges and is stable around every rising `spi_clk` edge, where the receiver samples.
- `busy`=1 whenever state≠IDLE.
- `cmd_valid` and `cmd_data` are ignored outside IDLE. There is no buffering; changes to `cmd_data` after accept do not affect the frame.
- `rst` asserted mid-frame: at the next edge all outputs take their reset values. The frame is abandoned, `done` is not pulsed, and no partial frame is resumed.
- **Counter widths:**
  - Phase counter: `$clog2(CLK_DIV+1)` bits, counting 0..`CLK_DIV-1`.
  - Bit counter: `$clog2(CMD_WIDTH+1)` bits.
  - Neither counter wraps past its terminal value.

## Timing
- Let the accept edge close cycle 0. Then:
  - `cs` is low for cycles 1 through `(2·CMD_WIDTH+1)·CLK_DIV`.
  - GAP occupies the next `CLK_DIV` cycles.
  - `done` is high in the last GAP cycle.
  - `cmd_ready` is high the following cycle.
- Rising `spi_clk` edges occur at cycles `CLK_DIV+1 + 2k·CLK_DIV`, for k = 0..`CMD_WIDTH-1`.
- Frame-to-frame `cs`-high time is exactly `CLK_DIV+1` cycles when `cmd_valid` is held high: `CLK_DIV` GAP cycles plus one IDLE cycle.
- After reset release, `cmd_ready` rises one cycle after the first edge with `rst`=1.

## Structure
- Shared package `spi_pkg`:
  - state enum `spi_host_state_t` (IDLE, LOW, HIGH, HOLD, GAP);
  - `SPI_CMD_WIDTH`=4, shared with the client;
  - `SPI_MSB_FIRST`=1.
- One natural sub-module, `spi_phase_timer`. It is the `CLK_DIV` down-counter emitting a one-cycle `phase_end` tick, restarted on each state change.
- The FSM, shift register and bit counter stay in `spi_host`.

## Test plan
- **Reset:** hold `rst`=0 for 5 cycles with `cmd_valid`=1 → `cs`=1, `spi_clk`=0, `mosi`=0, `cmd_ready`=0, `busy`=0, `done`=0 throughout. After release, `cmd_ready`=1 one cycle later and no frame starts before it.
- **Single frame** (`CMD_WIDTH`=4, `CLK_DIV`=2, cmd 4'b1010):
  - `cs` low cycles 1–18;
  - `spi_clk` rises at cycles 3, 7, 11, 15 with `mosi` = 1, 0, 1, 0;
  - `busy` high cycles 1–20;
  - `done` only in cycle 20;
  - `cmd_ready` returns in cycle 21.
- **Back-to-back** (`cmd_valid` held, 4'h3 then 4'hC) → second accept at cycle 21, `cs` high exactly 3 cycles between frames, and the client-side capture reads 3 then C.
- **Ignored input:** change `cmd_data` to 4'h5 and pulse `cmd_valid` during cycles 1–10 of a 4'hA frame → serial bits remain 1, 0, 1, 0 and no second frame starts.
- **Mid-frame reset:** assert `rst` in cycle 9 → cycle 10 has `cs`=1 and `spi_clk`=0, with no `done`. After release, 4'h6 transfers correctly.
- **Minimum divider** (`CLK_DIV`=1, cmd 4'hF) → `spi_clk` toggles every cycle, 4 rising edges, `cs` low for exactly 9 cycles, `mosi`=1 at every rising edge.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command host and its client.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOW,
      HIGH,
      HOLD,
      GAP
   } spi_host_state_t;

   localparam int SPI_CMD_WIDTH = 4;
   localparam bit SPI_MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_phase_timer.sv
// Phase timer: counts CLK_DIV cycles per SPI phase and flags the final cycle.
// Latency: phase_end_o is high in the CLK_DIV-th cycle after restart_i.
// Backpressure: none; restart_i reloads the counter unconditionally.
module spi_phase_timer #(
   parameter int CLK_DIV = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic restart_i,
   output logic phase_end_o,
   output logic phase_pre_o
);

   localparam int CNT_W = $clog2(CLK_DIV + 1);
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;

   // Down-count from CLK_DIV-1 to zero and park there until the next restart.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         cnt_q <= LOAD;
      end else if (restart_i) begin
         cnt_q <= LOAD;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   // phase_pre_o lets the host register outputs that must appear in the last cycle.
   assign phase_end_o = (cnt_q == '0);
   assign phase_pre_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/spi_host.sv
// SPI mode-0 host: serialises one command word per frame on spi_clk/mosi under cs.
// Latency: cs falls the cycle after accept; frame lasts (2*CMD_WIDTH+2)*CLK_DIV cycles.
// Backpressure: cmd_ready is high only in IDLE; no buffering of further commands.
module spi_host
   import spi_pkg::*;
#(
   parameter int CMD_WIDTH = SPI_CMD_WIDTH,
   parameter int CLK_DIV   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CMD_WIDTH-1:0] cmd_data,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   output logic                 busy,
   output logic                 done,
   output logic                 spi_clk,
   output logic                 mosi,
   output logic                 cs
);

   localparam int BIT_W = $clog2(CMD_WIDTH + 1);

   spi_host_state_t      state_q;
   logic [CMD_WIDTH-1:0] sreg_q;
   logic [CMD_WIDTH-1:0] sreg_d;
   logic [BIT_W-1:0]     bit_cnt_q;
   logic                 cmd_ready_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 spi_clk_q;
   logic                 mosi_q;
   logic                 cs_q;
   logic                 accept;
   logic                 restart;
   logic                 phase_end;
   logic                 phase_pre;

   assign accept = (state_q == IDLE) && cmd_valid && cmd_ready_q;

   // Every non-IDLE state leaves on phase_end, so the timer restarts on any state change.
   assign restart = (state_q == IDLE) ? accept : phase_end;

   // Next shift-register contents when advancing to the following bit.
   assign sreg_d = SPI_MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);

   spi_phase_timer #(
      .CLK_DIV(CLK_DIV)
   ) u_timer (
      .clk_i      (clk),
      .rst_i      (rst),
      .restart_i  (restart),
      .phase_end_o(phase_end),
      .phase_pre_o(phase_pre)
   );

   // Frame FSM; all outputs are registered and change together with the state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         sreg_q      <= '0;
         bit_cnt_q   <= '0;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         spi_clk_q   <= 1'b0;
         mosi_q      <= 1'b0;
         cs_q        <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cs_q      <= 1'b1;
               spi_clk_q <= 1'b0;
               if (accept) begin
                  state_q     <= LOW;
                  sreg_q      <= cmd_data;
                  bit_cnt_q   <= BIT_W'(CMD_WIDTH - 1);
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  cs_q        <= 1'b0;
                  mosi_q      <= SPI_MSB_FIRST ? cmd_data[CMD_WIDTH-1] : cmd_data[0];
               end else begin
                  cmd_ready_q <= 1'b1;
               end
            end
            LOW: begin
               if (phase_end) begin
                  state_q   <= HIGH;
                  spi_clk_q <= 1'b1;
               end
            end
            HIGH: begin
               if (phase_end) begin
                  spi_clk_q <= 1'b0;
                  if (bit_cnt_q != '0) begin
                     // Data moves only with the falling spi_clk edge.
                     state_q   <= LOW;
                     sreg_q    <= sreg_d;
                     mosi_q    <= SPI_MSB_FIRST ? sreg_d[CMD_WIDTH-1] : sreg_d[0];
                     bit_cnt_q <= bit_cnt_q - BIT_W'(1);
                  end else begin
                     state_q <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (phase_end) begin
                  state_q <= GAP;
                  cs_q    <= 1'b1;
                  // A one-cycle GAP is also its last cycle.
                  done_q  <= (CLK_DIV == 1);
               end
            end
            GAP: begin
               if (phase_end) begin
                  state_q     <= IDLE;
                  busy_q      <= 1'b0;
                  cmd_ready_q <= 1'b1;
               end else if (phase_pre) begin
                  done_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b0;
               cs_q        <= 1'b1;
               spi_clk_q   <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign spi_clk   = spi_clk_q;
   assign mosi      = mosi_q;
   assign cs        = cs_q;

endmodule

// File: tb/tb_spi_host.sv
// Scoreboard bench for spi_host: unit 0 uses CLK_DIV=2, unit 1 uses CLK_DIV=1.
// Stimulus pushes the expected frame; a per-unit monitor captures and compares it.
// Frame times are relative to the accept edge, which closes cycle 0.
module tb_spi_host;

   typedef struct {
      logic [3:0] word;
      int         cs_last;
      int         first_rise;
      int         step;
      int         done_at;
      int         cs_gap;
      int         acc_dist;
      bit         abort;
   } frame_t;

   logic       clk;
   logic [1:0] rst_v;
   logic [1:0] valid_v;
   logic [3:0] data_v [2];
   wire  [1:0] ready_v, busy_v, done_v, sck_v, mosi_v, cs_v;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   frame_t exp_q [2][$];

   spi_host #(.CMD_WIDTH(4), .CLK_DIV(2)) dut0 (
      .clk(clk), .rst(rst_v[0]), .cmd_data(data_v[0]), .cmd_valid(valid_v[0]),
      .cmd_ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .spi_clk(sck_v[0]), .mosi(mosi_v[0]), .cs(cs_v[0]));

   spi_host #(.CMD_WIDTH(4), .CLK_DIV(1)) dut1 (
      .clk(clk), .rst(rst_v[1]), .cmd_data(data_v[1]), .cmd_valid(valid_v[1]),
      .cmd_ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .spi_clk(sck_v[1]), .mosi(mosi_v[1]), .cs(cs_v[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int u, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL u%0d %s: got %0d, expected %0d", u, name, act, exp);
      end
   endtask

   function automatic frame_t mk(input logic [3:0] w, input int cs_last, input int first_rise,
                                 input int step, input int done_at, input int cs_gap,
                                 input int acc_dist, input bit abort);
      frame_t f;
      f.word = w; f.cs_last = cs_last; f.first_rise = first_rise; f.step = step;
      f.done_at = done_at; f.cs_gap = cs_gap; f.acc_dist = acc_dist; f.abort = abort;
      return f;
   endfunction

   // Monitor: acts as the client, capturing mosi on each rising spi_clk.
   task automatic monitor(input int u);
      frame_t e;
      bit     in_frame = 0;
      logic   prev_sck = 1'b0;
      logic [3:0] word = '0;
      int t0 = 0, rel = 0, nrise = 0, cs_first = -1, cs_last = -1;
      int done_cnt = 0, done_at = -1, busy_n = 0;
      int prev_t0 = -1000, prev_cs_end = -1000;
      int rise_at [4];
      forever begin
         @(negedge clk);
         if (!rst_v[u]) begin
            if (in_frame) begin
               check("abort_expected", u, int'(e.abort), 1);
               check("abort_no_done", u, done_cnt, 0);
            end
            in_frame = 0;
            prev_sck = 1'b0;
            continue;
         end
         if (in_frame) begin
            rel = cyc - t0;
            if (!cs_v[u]) begin
               if (cs_first < 0) cs_first = rel;
               cs_last = rel;
            end
            if (sck_v[u] && !prev_sck) begin
               if (nrise < 4) rise_at[nrise] = rel;
               word = {word[2:0], mosi_v[u]};
               nrise++;
            end
            if (busy_v[u]) busy_n++;
            if (done_v[u]) begin
               done_cnt++;
               done_at = rel;
            end
            if (ready_v[u]) begin
               check("frame_aborted", u, int'(e.abort), 0);
               check("word", u, int'(word), int'(e.word));
               check("rise_count", u, nrise, 4);
               check("cs_first", u, cs_first, 1);
               check("cs_last", u, cs_last, e.cs_last);
               check("first_rise", u, rise_at[0], e.first_rise);
               for (int k = 1; k < 4; k++)
                  check("rise_step", u, rise_at[k] - rise_at[k-1], e.step);
               check("done_count", u, done_cnt, 1);
               check("done_at", u, done_at, e.done_at);
               check("busy_cycles", u, busy_n, e.done_at);
               check("ready_return", u, rel, e.done_at + 1);
               if (e.cs_gap > 0)
                  check("cs_high_gap", u, t0 + cs_first - prev_cs_end - 1, e.cs_gap);
               prev_cs_end = t0 + cs_last;
               prev_t0 = t0;
               in_frame = 0;
            end
         end
         if (!in_frame && valid_v[u] && ready_v[u]) begin
            if (exp_q[u].size() == 0) begin
               check("unexpected_frame", u, 1, 0);
            end else begin
               e = exp_q[u].pop_front();
               if (e.acc_dist > 0) check("accept_spacing", u, cyc - prev_t0, e.acc_dist);
               t0 = cyc; in_frame = 1; word = '0; nrise = 0;
               cs_first = -1; cs_last = -1; done_cnt = 0; done_at = -1; busy_n = 0;
               for (int k = 0; k < 4; k++) rise_at[k] = -1;
            end
         end
         prev_sck = sck_v[u];
      end
   endtask

   // Called just after a rising edge; returns just after the accept edge.
   task automatic send(input int u, input logic [3:0] d, input bit keep);
      int n = 0;
      data_v[u]  = d;
      valid_v[u] = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!ready_v[u] && n < 200);
      check("accept_wait", u, int'(ready_v[u]), 1);
      @(posedge clk);
      #1;
      if (!keep) valid_v[u] = 1'b0;
   endtask

   task automatic wait_idle(input int u);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(ready_v[u] && !busy_v[u]) && n < 200);
      check("wait_idle", u, int'(ready_v[u] && !busy_v[u]), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b;
      rst_v     = 2'b00;
      valid_v   = 2'b01;
      data_v[0] = 4'hA;
      data_v[1] = 4'h0;
      fork
         monitor(0);
         monitor(1);
      join_none

      // Reset held with cmd_valid high; the frame may only start after cmd_ready.
      exp_q[0].push_back(mk(4'hA, 18, 3, 4, 20, 0, 0, 0));
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         for (int u = 0; u < 2; u++)
            check("reset_outputs", u,
                  int'({cs_v[u], sck_v[u], mosi_v[u], ready_v[u], busy_v[u], done_v[u]}),
                  int'(6'b100000));
      end
      @(posedge clk);
      #1;
      rst_v = 2'b11;
      @(posedge clk);
      @(negedge clk);
      check("ready_after_release", 0,
            int'({cs_v[0], ready_v[0], busy_v[0]}), int'(3'b110));
      @(posedge clk);
      #1;
      valid_v[0] = 1'b0;
      wait_idle(0);

      // Back-to-back frames with cmd_valid held.
      exp_q[0].push_back(mk(4'h3, 18, 3, 4, 20, 0, 0, 0));
      exp_q[0].push_back(mk(4'hC, 18, 3, 4, 20, 3, 21, 0));
      send(0, 4'h3, 1);
      send(0, 4'hC, 0);
      wait_idle(0);

      // Input changes during a frame must be ignored.
      exp_q[0].push_back(mk(4'hA, 18, 3, 4, 20, 0, 0, 0));
      send(0, 4'hA, 0);
      repeat (2) @(posedge clk);
      #1;
      data_v[0]  = 4'h5;
      valid_v[0] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      valid_v[0] = 1'b0;
      wait_idle(0);
      b = 0;
      repeat (6) begin
         @(negedge clk);
         if (busy_v[0]) b++;
      end
      check("no_second_frame", 0, b, 0);
      @(posedge clk);
      #1;

      // Reset asserted in cycle 9 of a frame.
      exp_q[0].push_back(mk(4'h9, 0, 0, 0, 0, 0, 0, 1));
      send(0, 4'h9, 0);
      repeat (8) @(posedge clk);
      #1;
      rst_v[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midframe_reset_out", 0,
            int'({cs_v[0], sck_v[0], done_v[0]}), int'(3'b100));
      @(posedge clk);
      #1;
      rst_v[0] = 1'b1;
      exp_q[0].push_back(mk(4'h6, 18, 3, 4, 20, 0, 0, 0));
      send(0, 4'h6, 0);
      wait_idle(0);

      // Minimum divider on unit 1.
      exp_q[1].push_back(mk(4'hF, 9, 2, 2, 10, 0, 0, 0));
      send(1, 4'hF, 0);
      wait_idle(1);

      repeat (3) @(posedge clk);
      check("queue_empty", 0, exp_q[0].size(), 0);
      check("queue_empty", 1, exp_q[1].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
